// File: rtl/pwm_if.sv
// Control/observation bundle for the fixed-period PWM generator.
// The master side drives the start strobe and duty request and observes
// the waveform plus the debug/display values.
interface pwm_if #(
    parameter int WIDTH = 7
);
    logic             en;
    logic [WIDTH-1:0] duty_cycle;
    logic             out;
    logic [WIDTH-1:0] clock_count;
    logic [WIDTH-1:0] segments;

    modport master (
        output en,
        output duty_cycle,
        input  out,
        input  clock_count,
        input  segments
    );

    modport slave (
        input  en,
        input  duty_cycle,
        output out,
        output clock_count,
        output segments
    );
endinterface

// File: rtl/pwm.sv
// Fixed-period pulse-width modulator.
// A single en strobe arms the generator; from then on it produces a
// continuous waveform whose high time per period equals the duty value
// latched at the start of that period. Only clr_n stops it.
module pwm #(
    parameter int WIDTH  = 7,
    parameter int PERIOD = 100
) (
    input  logic  clk,
    input  logic  clr_n,
    pwm_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] LAST_W   = WIDTH'(PERIOD - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] seg_reg;
    logic [WIDTH-1:0] seg_next;
    logic [WIDTH-1:0] duty_clamped;

    // Requests above a full period saturate at 100 % duty.
    always_comb begin
        duty_clamped = bus.duty_cycle;
        if (int'(bus.duty_cycle) > PERIOD) begin
            duty_clamped = PERIOD_W;
        end
    end

    // Next-state and datapath decode; the duty shadow only reloads on
    // arming and on the period wrap so a period is never cut short.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        seg_next   = seg_reg;
        unique case (state_reg)
            ST_IDLE: begin
                count_next = '0;
                if (bus.en) begin
                    state_next = ST_RUN;
                    seg_next   = duty_clamped;
                end
            end
            ST_RUN: begin
                if (count_reg == LAST_W) begin
                    count_next = '0;
                    seg_next   = duty_clamped;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // State, period counter and duty shadow registers with async clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            seg_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            seg_reg   <= seg_next;
        end
    end

    // Waveform decoded purely from registers, so it is glitch-free with
    // respect to duty_cycle and en and clears the instant clr_n falls.
    assign bus.out         = (state_reg == ST_RUN) && (count_reg < seg_reg);
    assign bus.clock_count = count_reg;
    assign bus.segments    = seg_reg;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for the PWM generator: a cycle-index model checked
// every cycle, plus directed literal checks at the interesting points.
module tb_pwm;
    localparam int WIDTH  = 7;
    localparam int PERIOD = 100;

    logic clk;
    logic clr_n;
    int   checks;
    int   errors;
    bit   started;

    pwm_if #(.WIDTH(WIDTH)) bif ();

    pwm #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: number of cycles since arming; position and period boundaries
    // follow directly from modular arithmetic on that number.
    bit m_running;
    int m_t;
    int m_seg;

    function automatic int clampd(input int d);
        return (d > PERIOD) ? PERIOD : d;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_running <= 1'b0;
            m_t       <= 0;
            m_seg     <= 0;
        end else if (!m_running) begin
            if (bif.en) begin
                m_running <= 1'b1;
                m_t       <= 0;
                m_seg     <= clampd(int'(bif.duty_cycle));
            end
        end else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % PERIOD == 0) m_seg <= clampd(int'(bif.duty_cycle));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_count", int'(bif.clock_count), m_running ? (m_t % PERIOD) : 0);
            chk("model_seg", int'(bif.segments), m_seg);
            chk("model_out", int'(bif.out),
                (m_running && ((m_t % PERIOD) < m_seg)) ? 1 : 0);
        end
    end

    task automatic wait_count(input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(bif.clock_count) != v && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL wait_count: clock_count never reached %0d (now %0d)", v, bif.clock_count);
        end
    endtask

    task automatic pulse_en(input int d);
        @(negedge clk);
        #1;
        bif.duty_cycle = WIDTH'(d);
        bif.en = 1'b1;
        @(negedge clk);
        #1;
        bif.en = 1'b0;
        $display("start duty=%0d seg=%0d out=%0d", d, bif.segments, bif.out);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        clr_n = 1'b0;
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        $display("reset applied");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        started = 1'b0;
        clr_n = 1'b1;
        bif.en = 1'b0;
        bif.duty_cycle = '0;

        // Reset then idle
        #3;
        clr_n = 1'b0;
        started = 1'b1;
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("idle_out", int'(bif.out), 0);
        chk("idle_count", int'(bif.clock_count), 0);
        chk("idle_seg", int'(bif.segments), 0);
        $display("idle: out=%0d count=%0d seg=%0d", bif.out, bif.clock_count, bif.segments);

        // Basic 90 %
        pulse_en(90);
        chk("first_out", int'(bif.out), 1);
        chk("first_count", int'(bif.clock_count), 0);
        chk("first_seg", int'(bif.segments), 90);
        wait_count(89);
        chk("p90_last_high", int'(bif.out), 1);
        wait_count(90);
        chk("p90_first_low", int'(bif.out), 0);
        for (int p = 0; p < 4; p++) begin
            wait_count(99);
            chk("p90_end_low", int'(bif.out), 0);
            wait_count(0);
            chk("p90_wrap_high", int'(bif.out), 1);
            $display("period %0d start: seg=%0d out=%0d", p + 2, bif.segments, bif.out);
        end

        // Mid-period change to 30
        wait_count(40);
        #1;
        bif.duty_cycle = 7'd30;
        wait_count(89);
        chk("mid_keep_seg", int'(bif.segments), 90);
        chk("mid_keep_out", int'(bif.out), 1);
        wait_count(0);
        chk("new_seg", int'(bif.segments), 30);
        chk("new_out0", int'(bif.out), 1);
        wait_count(29);
        chk("p30_last_high", int'(bif.out), 1);
        wait_count(30);
        chk("p30_first_low", int'(bif.out), 0);
        $display("mid-period change: seg=%0d", bif.segments);

        // Re-enable while running is ignored
        wait_count(50);
        #1;
        bif.en = 1'b1;
        @(negedge clk);
        chk("reen_count", int'(bif.clock_count), 51);
        #1;
        bif.en = 1'b0;
        $display("re-enable ignored: count=%0d", bif.clock_count);

        // Reset mid-run clears immediately
        wait_count(70);
        #2;
        clr_n = 1'b0;
        #1;
        chk("rst_out", int'(bif.out), 0);
        chk("rst_count", int'(bif.clock_count), 0);
        chk("rst_seg", int'(bif.segments), 0);
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle_count", int'(bif.clock_count), 0);
        chk("post_rst_idle_out", int'(bif.out), 0);
        $display("mid-run reset: count=%0d out=%0d", bif.clock_count, bif.out);

        // duty 0: never high
        pulse_en(0);
        chk("d0_out", int'(bif.out), 0);
        repeat (150) @(negedge clk);
        chk("d0_seg", int'(bif.segments), 0);
        do_reset();

        // duty 100: always high
        pulse_en(100);
        chk("d100_seg", int'(bif.segments), 100);
        wait_count(99);
        chk("d100_last", int'(bif.out), 1);
        wait_count(0);
        chk("d100_wrap", int'(bif.out), 1);
        do_reset();

        // duty 120: clamped to 100
        pulse_en(120);
        chk("d120_seg", int'(bif.segments), 100);
        wait_count(99);
        chk("d120_last", int'(bif.out), 1);
        #1;
        bif.duty_cycle = 7'd127;
        wait_count(0);
        chk("d127_seg", int'(bif.segments), 100);
        wait_count(99);
        chk("d127_last", int'(bif.out), 1);
        do_reset();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
